// File: rtl/parent_feeder_pkg.sv
// Shared definitions for the kid/parent meal-and-book handshake.
// Both ends of the protocol take their state encodings from here.
// The parent state is a 3-bit code. Codes 6 and 7 are unused and
// recover to IDLE.
package parent_feeder_pkg;

  // Parent (caretaker) states.
  typedef enum logic [2:0] {
    P_IDLE      = 3'd0,
    P_COOK      = 3'd1,
    P_SERVE     = 3'd2,
    P_WAIT_BOOK = 3'd3,
    P_READ      = 3'd4,
    P_STARVE    = 3'd5
  } parent_state_t;

  // Kid states, so the requesting side uses the same encodings.
  typedef enum logic [1:0] {
    K_PLAY    = 2'd0,
    K_HUNGRY  = 2'd1,
    K_EAT     = 2'd2,
    K_READ    = 2'd3
  } kid_state_t;

  // One timer is shared by the cook delay and the book delay.
  localparam int TIMER_W  = 8;
  localparam int PANTRY_W = 8;

  // A delay of N cycles loads N-1: the cycle in which the timer
  // reads zero is itself the last cycle spent in the state.
  function automatic logic [TIMER_W-1:0] delay_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/parent_feeder_if.sv
// Handshake bundle between the kid and the parent feeder.
//   request      : kid -> parent, registered hunger level
//   restock      : kid side -> parent, one-cycle pulse that refills the pantry
//   meal, book   : parent -> kid, one-cycle pulses
//   busy         : parent -> kid, parent not idle
//   pantry_empty : parent -> kid, no meals left
//   meals_served : parent -> kid, saturating meal count (CNT_W bits)
// master = kid or bench side, slave = parent side.
interface parent_feeder_if #(
  parameter int CNT_W = 8
);
  logic             request;
  logic             restock;
  logic             meal;
  logic             book;
  logic             busy;
  logic             pantry_empty;
  logic [CNT_W-1:0] meals_served;

  modport master (
    output request, restock,
    input  meal, book, busy, pantry_empty, meals_served
  );

  modport slave (
    input  request, restock,
    output meal, book, busy, pantry_empty, meals_served
  );
endinterface

// File: rtl/parent_feeder_delay_timer.sv
// delay_timer: 8-bit loadable down-counter.
// The counter stops at zero and does not wrap.
//   clk, reset : clock and asynchronous active-high reset (clears count)
//   load       : load load_val (takes priority over en)
//   load_val   : reload value
//   en         : decrement while nonzero
//   zero       : count is zero
module delay_timer
  import parent_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/parent_feeder.sv
// parent_feeder: caretaker side of the kid request/meal/book handshake.
// When request is seen in IDLE and the pantry is not empty, the block
// does the following:
//   - cooks for COOK_CYCLES cycles;
//   - pulses meal for one cycle;
//   - waits BOOK_DELAY cycles;
//   - pulses book for one cycle.
// With an empty pantry the block parks in STARVE until it is restocked,
// or until the kid stops asking.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of parent_feeder_if
//                (request/restock in; meal/book/busy/pantry_empty/meals_served out)
module parent_feeder
  import parent_feeder_pkg::*;
#(
  parameter int COOK_CYCLES  = 3,
  parameter int BOOK_DELAY   = 2,
  parameter int PANTRY_DEPTH = 4,
  parameter int CNT_W        = 8
)(
  input  logic            clk,
  input  logic            reset,
  parent_feeder_if.slave  bus
);

  localparam logic [PANTRY_W-1:0] PANTRY_FULL = PANTRY_W'(PANTRY_DEPTH);

  parent_state_t       state_q;
  parent_state_t       state_d;
  logic                load_timer;
  logic [TIMER_W-1:0]  load_val;
  logic                timer_en;
  logic                timer_zero;
  logic [PANTRY_W-1:0] pantry_q;
  logic [CNT_W-1:0]    served_q;
  logic                serve;
  logic                meal_o;
  logic                book_o;
  logic                busy_o;

  delay_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_timer),
    .load_val (load_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= P_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The timer is loaded on the transition into COOK or
  // WAIT_BOOK. The timer reaches zero in the last cycle of the delay.
  // request is deliberately not looked at in COOK/SERVE/WAIT_BOOK/READ:
  // the kid keeps request high for a couple of cycles after a meal,
  // and that must not start a second round of cooking.
  always_comb begin
    state_d    = P_IDLE;
    load_timer = 1'b0;
    load_val   = delay_load(COOK_CYCLES);
    case (state_q)
      P_IDLE: begin
        if (bus.request) begin
          if (pantry_q != '0) begin
            state_d    = P_COOK;
            load_timer = 1'b1;
          end else begin
            state_d = P_STARVE;
          end
        end else begin
          state_d = P_IDLE;
        end
      end
      P_COOK:      state_d = timer_zero ? P_SERVE : P_COOK;
      P_SERVE: begin
        state_d    = P_WAIT_BOOK;
        load_timer = 1'b1;
        load_val   = delay_load(BOOK_DELAY);
      end
      P_WAIT_BOOK: state_d = timer_zero ? P_READ : P_WAIT_BOOK;
      P_READ:      state_d = P_IDLE;
      P_STARVE: begin
        if (bus.restock) begin
          state_d    = P_COOK;
          load_timer = 1'b1;
        end else if (!bus.request) begin
          state_d = P_IDLE;
        end else begin
          state_d = P_STARVE;
        end
      end
      default:     state_d = P_IDLE;
    endcase
  end

  // Moore outputs, decoded from the state register only
  always_comb begin
    meal_o   = 1'b0;
    book_o   = 1'b0;
    busy_o   = 1'b1;
    timer_en = 1'b0;
    case (state_q)
      P_IDLE:      busy_o   = 1'b0;
      P_COOK:      timer_en = 1'b1;
      P_SERVE:     meal_o   = 1'b1;
      P_WAIT_BOOK: timer_en = 1'b1;
      P_READ:      book_o   = 1'b1;
      P_STARVE:    busy_o   = 1'b1;
      default:     busy_o   = 1'b1;
    endcase
  end

  assign serve = (state_q == P_SERVE);

  // Pantry: restock wins. A restock on the same cycle as a serve still
  // pays for the meal being served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pantry_q <= PANTRY_FULL;
    end else if (bus.restock) begin
      pantry_q <= serve ? (PANTRY_FULL - 1'b1) : PANTRY_FULL;
    end else if (serve) begin
      pantry_q <= pantry_q - 1'b1;
    end
  end

  // Meals served, holding at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_q <= '0;
    end else if (serve && (served_q != '1)) begin
      served_q <= served_q + CNT_W'(1);
    end
  end

  assign bus.meal         = meal_o;
  assign bus.book         = book_o;
  assign bus.busy         = busy_o;
  assign bus.pantry_empty = (pantry_q == '0);
  assign bus.meals_served = served_q;

endmodule
